qspi_mem_arbiter: RTL and testbench

- Shares the single QSPI memory controller between the CPU instruction-fetch port and the data load/store port.
- Decodes the 25-bit address into flash, RAM A or RAM B chip select.
- Sequences one transaction at a time: start, wait for done, stop/cancel.
- Sits between the TinyQV core memory interface and the QSPI controller driving uio[7:0].

---
 rtl/qspi_mem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_qspi_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_mem_arbiter.sv
// Arbitrates the TinyQV fetch and load/store ports onto one QSPI controller, one transaction at a time.
// Define QSPI_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority.
module qspi_mem_arbiter #(
    parameter int unsigned ADDR_W         = 25,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_req,
    input  logic [ADDR_W-1:0] instr_addr,
    input  logic              instr_stop,
    output logic              instr_ack,
    output logic              instr_err,
    output logic [31:0]       instr_rdata,
    input  logic              data_req,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic              data_we,
    input  logic [1:0]        data_len,
    input  logic [31:0]       data_wdata,
    output logic              data_ack,
    output logic              data_err,
    output logic [31:0]       data_rdata,
    output logic              mem_start,
    output logic [1:0]        mem_sel,
    output logic [23:0]       mem_addr,
    output logic              mem_write,
    output logic [1:0]        mem_len,
    output logic [31:0]       mem_wdata,
    output logic              mem_stop,
    input  logic              mem_busy,
    input  logic              mem_done,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t            state;
    logic [7:0]        cnt;
    logic              owner_instr;
    logic              err_flag;
`ifdef QSPI_ARB_RR_EN
    logic              last_instr;
`endif

    logic              instr_ok;
    logic              data_ok;
    logic              grant_instr;
    logic              grant_data;
    logic              flash_store;
    logic [ADDR_W-1:0] sel_addr;
    logic [1:0]        dec_sel;
    logic [23:0]       dec_addr;

    // A port whose ack/err is pulsing this cycle is still holding its request; do not re-serve it.
    always_comb begin
        instr_ok    = instr_req & ~instr_stop & ~instr_ack & ~instr_err;
        data_ok     = data_req & ~data_ack;
        grant_instr = 1'b0;
        grant_data  = 1'b0;
        if (data_ok && instr_ok) begin
`ifdef QSPI_ARB_RR_EN
            grant_instr = ~last_instr;
            grant_data  = last_instr;
`else
            grant_data  = 1'b1;
`endif
        end else begin
            grant_instr = instr_ok;
            grant_data  = data_ok;
        end

        sel_addr    = grant_data ? data_addr : instr_addr;
        dec_sel     = sel_addr[ADDR_W-1] ? (sel_addr[ADDR_W-2] ? 2'd2 : 2'd1) : 2'd0;
        dec_addr    = sel_addr[ADDR_W-1] ? {1'b0, sel_addr[22:0]} : sel_addr[23:0];
        flash_store = grant_data & data_we & ~data_addr[ADDR_W-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            owner_instr <= 1'b0;
            err_flag    <= 1'b0;
`ifdef QSPI_ARB_RR_EN
            last_instr  <= 1'b0;
`endif
            instr_ack   <= 1'b0;
            instr_err   <= 1'b0;
            instr_rdata <= '0;
            data_ack    <= 1'b0;
            data_err    <= 1'b0;
            data_rdata  <= '0;
            mem_start   <= 1'b0;
            mem_sel     <= '0;
            mem_addr    <= '0;
            mem_write   <= 1'b0;
            mem_len     <= '0;
            mem_wdata   <= '0;
            mem_stop    <= 1'b0;
        end else begin
            mem_start <= 1'b0;
            mem_stop  <= 1'b0;
            instr_ack <= 1'b0;
            instr_err <= 1'b0;
            data_ack  <= 1'b0;
            data_err  <= 1'b0;

            case (state)
                IDLE: begin
`ifdef QSPI_ARB_RR_EN
                    if (grant_instr || grant_data)
                        last_instr <= grant_instr;
`endif
                    if (flash_store) begin
                        data_ack <= 1'b1;
                        data_err <= 1'b1;
                    end else if (grant_instr || grant_data) begin
                        mem_start   <= 1'b1;
                        mem_sel     <= dec_sel;
                        mem_addr    <= dec_addr;
                        mem_write   <= grant_data & data_we;
                        mem_len     <= grant_data ? data_len : 2'd3;
                        mem_wdata   <= grant_data ? data_wdata : '0;
                        owner_instr <= grant_instr;
                        cnt         <= '0;
                        err_flag    <= 1'b0;
                        state       <= BUSY;
                    end
                end

                BUSY: begin
                    if (mem_done) begin
                        if (owner_instr) begin
                            instr_ack   <= 1'b1;
                            instr_rdata <= mem_rdata;
                        end else begin
                            data_ack    <= 1'b1;
                            data_rdata  <= mem_rdata;
                        end
                        state <= IDLE;
                    end else if (owner_instr && instr_stop) begin
                        mem_stop <= 1'b1;
                        err_flag <= 1'b0;
                        state    <= DRAIN;
                    end else if (cnt == TO_LAST) begin
                        mem_stop <= 1'b1;
                        err_flag <= 1'b1;
                        state    <= DRAIN;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                DRAIN: begin
                    // Late mem_done pulses are dropped; leave only once the controller is quiet.
                    if (!mem_busy && !mem_done) begin
                        state <= IDLE;
                        if (err_flag) begin
                            if (owner_instr) begin
                                instr_err <= 1'b1;
                            end else begin
                                data_ack <= 1'b1;
                                data_err <= 1'b1;
                            end
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qspi_mem_arbiter.sv
// Directed bench for qspi_mem_arbiter: fetch, stores, arbitration, cancel, timeout and reset.
// Arbitration expectations follow QSPI_ARB_RR_EN when it is defined.
module tb_qspi_mem_arbiter;

`ifdef QSPI_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        instr_req;
    logic [24:0] instr_addr;
    logic        instr_stop;
    logic        instr_ack;
    logic        instr_err;
    logic [31:0] instr_rdata;
    logic        data_req;
    logic [24:0] data_addr;
    logic        data_we;
    logic [1:0]  data_len;
    logic [31:0] data_wdata;
    logic        data_ack;
    logic        data_err;
    logic [31:0] data_rdata;
    logic        mem_start;
    logic [1:0]  mem_sel;
    logic [23:0] mem_addr;
    logic        mem_write;
    logic [1:0]  mem_len;
    logic [31:0] mem_wdata;
    logic        mem_stop;
    logic        mem_busy;
    logic        mem_done;
    logic [31:0] mem_rdata;

    int tests = 0;
    int fails = 0;

    qspi_mem_arbiter #(.ADDR_W(25), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .instr_req(instr_req), .instr_addr(instr_addr), .instr_stop(instr_stop),
        .instr_ack(instr_ack), .instr_err(instr_err), .instr_rdata(instr_rdata),
        .data_req(data_req), .data_addr(data_addr), .data_we(data_we),
        .data_len(data_len), .data_wdata(data_wdata),
        .data_ack(data_ack), .data_err(data_err), .data_rdata(data_rdata),
        .mem_start(mem_start), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_write(mem_write), .mem_len(mem_len), .mem_wdata(mem_wdata),
        .mem_stop(mem_stop), .mem_busy(mem_busy), .mem_done(mem_done),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        instr_req = 1'b0; instr_addr = '0; instr_stop = 1'b0;
        data_req = 1'b0; data_addr = '0; data_we = 1'b0; data_len = '0; data_wdata = '0;
        mem_busy = 1'b0; mem_done = 1'b0; mem_rdata = '0;

        // Reset state
        tick(); tick();
        chk("rst_mem_start", mem_start, 0);
        chk("rst_instr_ack", instr_ack, 0);
        chk("rst_data_ack", data_ack, 0);
        chk("rst_instr_rdata", instr_rdata, 0);
        rst = 1'b0;
        tick();

        // Flash fetch, done 6 cycles after start
        instr_req = 1'b1; instr_addr = 25'h0000100;
        tick();
        chk("fetch_start", mem_start, 1);
        chk("fetch_sel", mem_sel, 0);
        chk("fetch_addr", mem_addr, 32'h000100);
        chk("fetch_len", mem_len, 3);
        chk("fetch_write", mem_write, 0);
        mem_busy = 1'b1;
        tick();
        chk("fetch_start_pulse", mem_start, 0);
        repeat (5) tick();
        mem_done = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        chk("fetch_ack", instr_ack, 1);
        chk("fetch_rdata", instr_rdata, 32'hDEADBEEF);
        mem_done = 1'b0; mem_busy = 1'b0; instr_req = 1'b0; mem_rdata = '0;
        tick();
        chk("fetch_ack_pulse", instr_ack, 0);
        chk("fetch_no_restart", mem_start, 0);
        chk("fetch_rdata_hold", instr_rdata, 32'hDEADBEEF);

        // Halfword store to RAM B
        data_req = 1'b1; data_we = 1'b1; data_len = 2'd1;
        data_addr = 25'h1800040; data_wdata = 32'h1234;
        tick();
        chk("st_start", mem_start, 1);
        chk("st_sel", mem_sel, 2);
        chk("st_addr", mem_addr, 32'h000040);
        chk("st_write", mem_write, 1);
        chk("st_len", mem_len, 1);
        chk("st_wdata", mem_wdata, 32'h1234);
        mem_busy = 1'b1;
        tick();
        mem_done = 1'b1;
        tick();
        chk("st_ack", data_ack, 1);
        chk("st_err", data_err, 0);
        data_req = 1'b0; mem_done = 1'b0; mem_busy = 1'b0;
        tick();

        // Store to flash is refused without touching the controller
        data_req = 1'b1; data_we = 1'b1; data_len = 2'd3;
        data_addr = 25'h0000040; data_wdata = 32'h5678;
        tick();
        chk("fst_no_start", mem_start, 0);
        chk("fst_ack", data_ack, 1);
        chk("fst_err", data_err, 1);
        data_req = 1'b0; data_we = 1'b0;
        tick();
        chk("fst_ack_pulse", data_ack, 0);
        chk("fst_still_idle", mem_start, 0);

        // Simultaneous requests straight after reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        instr_req = 1'b1; instr_addr = 25'h0000200;
        data_req = 1'b1; data_addr = 25'h1000010; data_we = 1'b0; data_len = 2'd3;
        tick();
        chk("arb1_start", mem_start, 1);
        chk("arb1_sel", mem_sel, RR ? 0 : 1);
        chk("arb1_addr", mem_addr, RR ? 32'h200 : 32'h10);
        mem_busy = 1'b1; mem_done = 1'b1; mem_rdata = 32'h11111111;
        tick();
        chk("arb1_instr_ack", instr_ack, RR);
        chk("arb1_data_ack", data_ack, !RR);
        if (RR) instr_req = 1'b0; else data_req = 1'b0;
        mem_done = 1'b0;
        tick();
        chk("arb2_start", mem_start, 1);
        chk("arb2_sel", mem_sel, RR ? 1 : 0);
        mem_done = 1'b1; mem_rdata = 32'h22222222;
        tick();
        chk("arb2_instr_ack", instr_ack, !RR);
        chk("arb2_data_ack", data_ack, RR);
        chk("arb_instr_rdata", instr_rdata, RR ? 32'h11111111 : 32'h22222222);
        chk("arb_data_rdata", data_rdata, RR ? 32'h22222222 : 32'h11111111);
        instr_req = 1'b0; data_req = 1'b0; mem_done = 1'b0; mem_busy = 1'b0;
        tick();

        // Fetch cancelled 3 cycles in, data load waiting behind it
        instr_req = 1'b1; instr_addr = 25'h0000300;
        tick();
        chk("cx_start", mem_start, 1);
        mem_busy = 1'b1;
        data_req = 1'b1; data_addr = 25'h1800080; data_we = 1'b0; data_len = 2'd3;
        tick(); tick(); tick();
        instr_stop = 1'b1;
        tick();
        chk("cx_stop", mem_stop, 1);
        chk("cx_no_ack", instr_ack, 0);
        instr_stop = 1'b0; instr_req = 1'b0;
        tick();
        chk("cx_stop_pulse", mem_stop, 0);
        chk("cx_drain_no_start", mem_start, 0);
        mem_done = 1'b1;
        tick();
        chk("cx_late_done_dropped", instr_ack, 0);
        mem_done = 1'b0; mem_busy = 1'b0;
        tick();
        chk("cx_idle_no_ack", instr_ack, 0);
        chk("cx_idle_no_err", instr_err, 0);
        chk("cx_idle_no_start", mem_start, 0);
        tick();
        chk("cx_data_start", mem_start, 1);
        chk("cx_data_sel", mem_sel, 2);
        chk("cx_data_addr", mem_addr, 32'h000080);
        mem_busy = 1'b1; mem_done = 1'b1; mem_rdata = 32'h33333333;
        tick();
        chk("cx_data_ack", data_ack, 1);
        chk("cx_data_rdata", data_rdata, 32'h33333333);
        data_req = 1'b0; mem_done = 1'b0; mem_busy = 1'b0;
        tick();

        // Data load that never completes (timeout of 8)
        data_req = 1'b1; data_addr = 25'h1000020; data_we = 1'b0; data_len = 2'd3;
        tick();
        chk("to_start", mem_start, 1);
        mem_busy = 1'b1;
        repeat (7) tick();
        chk("to_no_stop_early", mem_stop, 0);
        tick();
        chk("to_stop", mem_stop, 1);
        chk("to_no_ack_yet", data_ack, 0);
        tick();
        chk("to_stop_pulse", mem_stop, 0);
        chk("to_wait_busy", data_ack, 0);
        mem_busy = 1'b0;
        tick();
        chk("to_ack", data_ack, 1);
        chk("to_err", data_err, 1);
        data_req = 1'b0;
        tick();
        chk("to_ack_pulse", data_ack, 0);
        chk("to_no_restart", mem_start, 0);

        // Reset in the middle of a RAM B fetch
        instr_req = 1'b1; instr_addr = 25'h1800400;
        tick();
        chk("rb_sel", mem_sel, 2);
        mem_busy = 1'b1;
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("rb_sel_cleared", mem_sel, 0);
        chk("rb_addr_cleared", mem_addr, 0);
        chk("rb_len_cleared", mem_len, 0);
        chk("rb_instr_rdata_cleared", instr_rdata, 0);
        chk("rb_data_rdata_cleared", data_rdata, 0);
        instr_req = 1'b0;
        tick();
        rst = 1'b0;
        mem_done = 1'b1; mem_rdata = 32'h44444444;
        tick();
        chk("rb_no_instr_ack", instr_ack, 0);
        chk("rb_no_data_ack", data_ack, 0);
        chk("rb_rdata_kept", instr_rdata, 0);
        mem_done = 1'b0; mem_busy = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
